// File: rtl/shift_rows_buf.sv
// shift_rows_buf
//   AES/Rijndael ShiftRows / InvShiftRows applied to a column-major state,
//   followed by a small circular output FIFO. The transform is pure wiring
//   and sits in front of the FIFO. Each entry stores {transformed data, inv}.
//   Latency is one cycle: a beat accepted at edge N is visible at the head
//   right after edge N.
//
// Parameters
//   NB    : state columns (4, 6 or 8)
//   DEPTH : FIFO entries (2, 4 or 8)
//
// Ports
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : input handshake
//   in_data [0:W-1]      : state, byte k = bits [8k:8k+7] = state(k%4, k/4)
//   in_inv               : 0 = ShiftRows, 1 = InvShiftRows
//   out_valid/out_ready  : output handshake
//   out_data [0:W-1]     : transformed state at FIFO head
//   out_inv              : inv flag of the head beat
//   count                : occupied entries
module shift_rows_buf #(
    parameter int NB    = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [0:32*NB-1]           in_data,
    input  logic                       in_inv,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [0:32*NB-1]           out_data,
    output logic                       out_inv,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int W  = 32*NB;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Row offsets; NB=8 uses the wider Rijndael spacing.
    localparam int C1 = 1;
    localparam int C2 = (NB == 8) ? 3 : 2;
    localparam int C3 = (NB == 8) ? 4 : 3;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_buf: NB must be 4, 6 or 8");
        end
        if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
            $error("shift_rows_buf: DEPTH must be 2, 4 or 8");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transform: both directions are fixed byte permutations; the inv bit
    // just picks which one is written into the FIFO.
    // ------------------------------------------------------------------
    logic [0:W-1] w_fwd;
    logic [0:W-1] w_inv;
    logic [0:W-1] w_xf;

    genvar gr, gc;
    generate
        for (gr = 0; gr < 4; gr++) begin : g_row
            localparam int OFF = (gr == 0) ? 0 : (gr == 1) ? C1 : (gr == 2) ? C2 : C3;
            for (gc = 0; gc < NB; gc++) begin : g_col
                localparam int SF = (gc + OFF) % NB;
                localparam int SI = (gc - OFF + NB) % NB;
                assign w_fwd[8*(4*gc+gr) +: 8] = in_data[8*(4*SF+gr) +: 8];
                assign w_inv[8*(4*gc+gr) +: 8] = in_data[8*(4*SI+gr) +: 8];
            end
        end
    endgenerate

    assign w_xf = in_inv ? w_inv : w_fwd;

    // ------------------------------------------------------------------
    // Circular FIFO. Handshake outputs depend only on r_count, so there is
    // no combinational path between the two sides.
    // ------------------------------------------------------------------
    logic [0:W]    r_mem [DEPTH];   // bits 0..W-1 data, bit W inv
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    logic [0:W]    w_head;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_head    = r_mem[r_rptr];
    assign out_data  = w_head[0:W-1];
    assign out_inv   = w_head[W];
    assign count     = r_count;

    // Storage is not reset; the head is only meaningful while out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_xf, in_inv};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PW'(DEPTH-1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(DEPTH-1)) ? '0 : r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rows_buf.sv
// Directed bench for shift_rows_buf: NB=4/DEPTH=2 instance for handshake,
// FIFO and known-answer vectors; NB=8/DEPTH=4 instance for the wide offsets.
module tb_shift_rows_buf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // NB=4, DEPTH=2
    logic         a_in_valid, a_in_ready, a_in_inv;
    logic [0:127] a_in_data;
    logic         a_out_valid, a_out_ready, a_out_inv;
    logic [0:127] a_out_data;
    logic [1:0]   a_count;

    // NB=8, DEPTH=4
    logic         b_in_valid, b_in_ready, b_in_inv;
    logic [0:255] b_in_data;
    logic         b_out_valid, b_out_ready, b_out_inv;
    logic [0:255] b_out_data;
    logic [2:0]   b_count;

    shift_rows_buf #(.NB(4), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_inv(a_in_inv),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_inv(a_out_inv),
        .count(a_count)
    );

    shift_rows_buf #(.NB(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_inv(b_in_inv),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_inv(b_out_inv),
        .count(b_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s miscompared", tag);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: data left-justified in 256 bits, nb columns used.
    function automatic logic [0:255] xf(input logic [0:255] d, input int nb, input bit inv);
        logic [0:255] o;
        int off [4];
        int sc;
        off[0] = 0;
        off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb == 8) ? 4 : 3;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                sc = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
                o[8*(4*c+r) +: 8] = d[8*(4*sc+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] m4(input logic [0:127] d, input bit inv);
        logic [0:255] t;
        t = xf({d, 128'h0}, 4, inv);
        return t[0:127];
    endfunction

    logic [0:127] v_seq, e_seq, f_in, f_out;
    logic [0:127] va, vb, vc, vd, vp, vq, cur;
    logic [0:255] x8, y8;

    initial begin
        v_seq = 128'h000102030405060708090a0b0c0d0e0f;
        e_seq = 128'h00050a0f04090e03080d02070c01060b;
        f_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
        f_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        va    = 128'h11223344_55667788_99aabbcc_ddeeff00;
        vb    = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        vc    = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        vd    = 128'ha5a5a5a5_00ff00ff_12345678_fedcba98;
        vp    = 128'h01010101_02020202_03030303_04040404;
        vq    = 128'h10203040_50607080_90a0b0c0_d0e0f000;

        rst = 1'b1;
        a_in_valid = 0; a_in_inv = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_out_ready = 0;
        tick; tick;
        chk("rst_count",    256'(a_count), 256'(0));
        chk("rst_outvalid", 256'(a_out_valid), 256'(0));
        chk("rst_inready",  256'(a_in_ready), 256'(1));
        rst = 1'b0;

        // Sequential bytes, forward, one-cycle latency
        a_in_valid = 1; a_in_data = v_seq; a_in_inv = 0; a_out_ready = 1;
        tick;
        chk("seq_valid", 256'(a_out_valid), 256'(1));
        chk("seq_data",  256'(a_out_data), 256'(e_seq));
        chk("seq_inv",   256'(a_out_inv), 256'(0));
        chk("seq_count", 256'(a_count), 256'(1));

        // FIPS-197 round-1 vector, then fed back inverse (push+pop each edge)
        a_in_data = f_in;
        tick;
        chk("fips_fwd",   256'(a_out_data), 256'(f_out));
        chk("fips_count", 256'(a_count), 256'(1));
        a_in_data = f_out; a_in_inv = 1;
        tick;
        chk("fips_inv",     256'(a_out_data), 256'(f_in));
        chk("fips_inv_flag",256'(a_out_inv), 256'(1));
        a_in_valid = 0;
        tick;
        chk("drain_count", 256'(a_count), 256'(0));
        chk("drain_valid", 256'(a_out_valid), 256'(0));

        // Fill DEPTH=2 with out_ready low, C held off, then drain in order
        a_out_ready = 0; a_in_valid = 1; a_in_inv = 0; a_in_data = va;
        tick;
        chk("fill_cnt1", 256'(a_count), 256'(1));
        a_in_data = vb;
        tick;
        chk("fill_cnt2",  256'(a_count), 256'(2));
        chk("full_rdy",   256'(a_in_ready), 256'(0));
        a_in_data = vc; a_in_inv = 1;
        tick;
        chk("full_hold_cnt", 256'(a_count), 256'(2));
        chk("full_head_a",   256'(a_out_data), 256'(m4(va, 1'b0)));
        a_in_data = 128'hffff0000_ffff0000_ffff0000_ffff0000;
        tick;
        chk("stall_data",  256'(a_out_data), 256'(m4(va, 1'b0)));
        chk("stall_valid", 256'(a_out_valid), 256'(1));
        a_in_data = vc; a_out_ready = 1;
        tick;
        chk("pop_a_cnt",  256'(a_count), 256'(1));
        chk("pop_a_rdy",  256'(a_in_ready), 256'(1));
        chk("head_b",     256'(a_out_data), 256'(m4(vb, 1'b0)));
        tick;
        chk("head_c",     256'(a_out_data), 256'(m4(vc, 1'b1)));
        chk("head_c_inv", 256'(a_out_inv), 256'(1));
        chk("c_cnt",      256'(a_count), 256'(1));
        a_in_valid = 0;
        tick;
        chk("abc_empty", 256'(a_count), 256'(0));

        // 100 beats streaming at count=1
        a_in_inv = 0; a_out_ready = 0; a_in_valid = 1;
        cur = {$urandom, $urandom, $urandom, $urandom};
        a_in_data = cur;
        tick;
        a_out_ready = 1;
        for (int i = 0; i < 100; i++) begin
            cur = {$urandom, $urandom, $urandom, $urandom};
            a_in_data = cur;
            tick;
            chk($sformatf("stream_cnt_%0d", i), 256'(a_count), 256'(1));
            chk($sformatf("stream_dat_%0d", i), 256'(a_out_data), 256'(m4(cur, 1'b0)));
        end
        a_in_valid = 0;
        tick;
        chk("stream_empty", 256'(a_count), 256'(0));

        // Async reset with two stale entries
        a_out_ready = 0; a_in_valid = 1; a_in_data = vp;
        tick;
        a_in_data = vq;
        tick;
        chk("pre_rst_cnt", 256'(a_count), 256'(2));
        a_in_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 256'(a_out_valid), 256'(0));
        chk("arst_count", 256'(a_count), 256'(0));
        chk("arst_ready", 256'(a_in_ready), 256'(1));
        tick;
        rst = 1'b0;
        a_in_valid = 1; a_in_data = vd; a_out_ready = 1;
        tick;
        chk("post_rst_cnt",  256'(a_count), 256'(1));
        chk("post_rst_head", 256'(a_out_data), 256'(m4(vd, 1'b0)));
        a_in_valid = 0;
        tick;
        chk("post_rst_empty", 256'(a_out_valid), 256'(0));
        chk("post_rst_cnt0",  256'(a_count), 256'(0));

        // NB=8: forward, byte spot checks, inverse back to identity
        b_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            x8 = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
            y8 = xf(x8, 8, 1'b0);
            b_in_valid = 1; b_in_inv = 0; b_in_data = x8;
            tick;
            chk($sformatf("nb8_fwd_%0d", i),  256'(b_out_data), 256'(y8));
            chk($sformatf("nb8_b10_%0d", i),  256'(b_out_data[8 +: 8]), 256'(x8[40 +: 8]));
            chk($sformatf("nb8_b30_%0d", i),  256'(b_out_data[24 +: 8]), 256'(x8[152 +: 8]));
            b_in_data = y8; b_in_inv = 1;
            tick;
            chk($sformatf("nb8_id_%0d", i),   256'(b_out_data), 256'(x8));
            chk($sformatf("nb8_inv_%0d", i),  256'(b_out_inv), 256'(1));
            b_in_valid = 0;
            tick;
            chk($sformatf("nb8_empty_%0d", i), 256'(b_count), 256'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
